// File: rtl/mux_n_stream.sv
// mux_n_stream: N-to-1 valid/ready stream mux with external-select or
// round-robin arbitration into a single registered output stage.
module mux_n_stream #(
    parameter int N = 8,
    parameter int W = 8,
    localparam int M = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [M-1:0]   sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    output logic [M-1:0]   out_sel,
    input  logic           out_ready
);

    logic         free;
    logic         acc;
    logic         hit;
    logic [N-1:0] g;
    logic [M-1:0] gidx;
    logic [M-1:0] idx;
    logic [M-1:0] ptr;

    // Round-robin search starts at ptr; M-bit index arithmetic wraps mod N.
    always_comb begin
        g    = '0;
        gidx = '0;
        idx  = '0;
        hit  = 1'b0;
        if (mode) begin
            for (int k = 0; k < N; k++) begin
                idx = ptr + M'(k);
                if (!hit && in_valid[idx]) begin
                    hit    = 1'b1;
                    g[idx] = 1'b1;
                    gidx   = idx;
                end
            end
        end else begin
            g[sel] = 1'b1;
            gidx   = sel;
        end
    end

    assign free     = !out_valid || out_ready;
    assign in_ready = (free && rst_n) ? g : '0;
    assign acc      = |(in_valid & in_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (free) begin
                out_valid <= acc;
            end
            if (acc) begin
                out_data <= in_data[gidx*W +: W];
                out_sel  <= gidx;
                if (mode) begin
                    ptr <= gidx + M'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_n_stream.sv
// tb_mux_n_stream: directed checks plus a reference model and
// scoreboard for mux_n_stream (N=8, W=8).
module tb_mux_n_stream;

    localparam int N = 8;
    localparam int W = 8;
    localparam int M = 3;

    typedef struct packed {
        logic [M-1:0] ch;
        logic [W-1:0] d;
    } ent_t;

    logic           clk;
    logic           rst_n;
    logic           mode;
    logic [M-1:0]   sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic [M-1:0]   out_sel;
    logic           out_ready;

    int   total = 0;
    int   bad = 0;
    ent_t q[$];
    int   m_ptr = 0;
    logic m_ov = 1'b0;
    logic m_acc_d = 1'b0;
    int   m_ch = 0;

    mux_n_stream #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .sel      (sel),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_sel  (out_sel),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        logic [N-1:0] g;
        logic         free;
        logic         found;
        logic         acc;
        int           gi;
        int           idx;
        ent_t         e;
        if (!rst_n) begin
            q.delete();
            m_ov    = 1'b0;
            m_ptr   = 0;
            m_acc_d = 1'b0;
            chk("rst_rdy", 32'(in_ready), 32'd0);
            chk("rst_ov", 32'(out_valid), 32'd0);
        end else begin
            chk("m_ov", 32'(out_valid), 32'(m_ov));
            free  = !m_ov || out_ready;
            g     = '0;
            gi    = 0;
            found = 1'b0;
            if (!mode) begin
                gi    = int'(sel);
                g[gi] = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && in_valid[idx]) begin
                        found  = 1'b1;
                        g[idx] = 1'b1;
                        gi     = idx;
                    end
                end
            end
            chk("m_rdy", 32'(in_ready), free ? 32'(g) : 32'd0);
            if (m_ov && out_ready) begin
                if (q.size() == 0) begin
                    chk("m_empty", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("m_sel", 32'(out_sel), 32'(e.ch));
                    chk("m_data", 32'(out_data), 32'(e.d));
                end
            end
            acc = free && |(g & in_valid);
            if (acc) begin
                e.ch = M'(gi);
                e.d  = in_data[gi*W +: W];
                q.push_back(e);
                if (mode) m_ptr = (gi + 1) % N;
            end
            if (free) m_ov = acc;
            m_acc_d = acc;
            m_ch    = gi;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 | 8'(i);
        step();
        step();
        chk("rst_ov0", 32'(out_valid), 32'd0);
        chk("rst_dat0", 32'(out_data), 32'd0);
        chk("rst_sel0", 32'(out_sel), 32'd0);
        rst_n = 1'b1;
        step();

        // external select
        mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        #2 chk("m0_rdy", 32'(in_ready), 32'h20);
        step();
        chk("m0_dat", 32'(out_data), 32'hA5);
        chk("m0_sel", 32'(out_sel), 32'd5);
        chk("m0_ov", 32'(out_valid), 32'd1);
        in_valid = 8'hDF;
        #2 chk("m0_rdy2", 32'(in_ready), 32'h20);
        step();
        chk("m0_drop", 32'(out_valid), 32'd0);

        // round-robin fairness with wrap
        mode = 1'b1; in_valid = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("rr_sel", 32'(out_sel), 32'(k % N));
            chk("rr_ov", 32'(out_valid), 32'd1);
        end

        // sparse round-robin: move ptr to 3 first
        in_valid = 8'h04;
        #2 chk("sp_rdy0", 32'(in_ready), 32'h04);
        step();
        chk("sp_sel0", 32'(out_sel), 32'd2);
        in_valid = 8'h84;
        #2 chk("sp_rdy1", 32'(in_ready), 32'h80);
        step();
        chk("sp_sel1", 32'(out_sel), 32'd7);
        #2 chk("sp_rdy2", 32'(in_ready), 32'h04);
        step();
        chk("sp_sel2", 32'(out_sel), 32'd2);
        step();
        chk("sp_sel3", 32'(out_sel), 32'd7);

        // backpressure
        out_ready = 1'b0; in_valid = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            #2 chk("bp_rdy", 32'(in_ready), 32'd0);
            step();
            chk("bp_sel", 32'(out_sel), 32'd7);
            chk("bp_dat", 32'(out_data), 32'hA7);
            chk("bp_ov", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #2 chk("bp_rel", 32'(in_ready), 32'h01);
        step();
        chk("bp_sel2", 32'(out_sel), 32'd0);
        chk("bp_dat2", 32'(out_data), 32'hA0);
        chk("bp_ov2", 32'(out_valid), 32'd1);

        // async reset mid-stall
        out_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("ar_ov", 32'(out_valid), 32'd0);
        chk("ar_dat", 32'(out_data), 32'd0);
        chk("ar_sel", 32'(out_sel), 32'd0);
        chk("ar_rdy", 32'(in_ready), 32'd0);
        step();
        step();
        rst_n = 1'b1; out_ready = 1'b1; mode = 1'b1; in_valid = 8'hFF;
        #2 chk("ar_rdy2", 32'(in_ready), 32'h01);
        step();
        chk("ar_first", 32'(out_sel), 32'd0);

        // mode switch each cycle under full load
        for (int k = 0; k < 40; k++) begin
            mode = k[0];
            sel  = M'($urandom);
            #2 chk("ms_one", 32'($countones(in_ready & in_valid)), 32'd1);
            step();
            if (m_acc_d) in_data[m_ch*W +: W] = 8'($urandom);
        end

        // random traffic
        for (int k = 0; k < 300; k++) begin
            mode      = 1'($urandom);
            sel       = M'($urandom);
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (m_acc_d) in_data[m_ch*W +: W] = 8'($urandom);
        end

        in_valid  = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("drain_ov", 32'(out_valid), 32'd0);
        chk("drain_q", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
